ivl_uvm_rr_arbiter: RTL and testbench

IVL_UVM_RR_ARBITER -- requirements
Module: ivl_uvm_rr_arbiter

---
 rtl/ivl_uvm_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_ivl_uvm_rr_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ivl_uvm_rr_arbiter.sv
// ivl_uvm_rr_arbiter
// Round-robin arbiter that grants one requester at a time. A grant ends when
// the owner drops its request or after a tenure of MAX_HOLD cycles. Every
// tenure is followed by at least one idle cycle. The search for the next owner
// starts just past the previous owner.
//
// Parameters
//   NUM_REQ  : number of requesters (2..16)
//   MAX_HOLD : maximum grant tenure in cycles (2..255)
// Ports
//   clk       in   sole clock, rising edge
//   rst_n     in   synchronous active-low reset
//   en        in   arbitration enable; gates new grants only
//   req       in   per-requester request, level-held for the tenure
//   gnt       out  registered grant vector, zero-or-one-hot
//   gnt_id    out  registered index of current/most recent owner
//   gnt_valid out  registered, high exactly when gnt is non-zero
//   timeout   out  registered one-cycle pulse on MAX_HOLD revocation
module ivl_uvm_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       gnt_valid,
  output logic                       timeout
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int HCW = $clog2(MAX_HOLD);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t           r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [IDW-1:0]   r_gnt_id;
  logic [IDW-1:0]   r_ptr;
  logic [HCW-1:0]   r_hold_cnt;
  logic             r_gnt_valid;
  logic             r_timeout;

  state_t           w_next_state;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IDW-1:0]   w_gnt_id;
  logic [IDW-1:0]   w_ptr;
  logic [HCW-1:0]   w_hold_cnt;
  logic             w_timeout;
  logic             w_pick_found;
  logic [IDW-1:0]   w_pick_id;
  logic             w_hold_max;

  // Rotating priority search: first set request at or above r_ptr, wrapping.
  always_comb begin : pick_search
    int unsigned v_idx;
    w_pick_found = 1'b0;
    w_pick_id    = '0;
    v_idx        = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      v_idx = (int'(r_ptr) + i) % NUM_REQ;
      if (!w_pick_found && req[IDW'(v_idx)]) begin
        w_pick_found = 1'b1;
        w_pick_id    = IDW'(v_idx);
      end
    end
  end

  assign w_hold_max = (r_hold_cnt == HCW'(MAX_HOLD - 1));

  always_comb begin
    w_next_state = r_state;
    w_gnt        = '0;
    w_gnt_id     = r_gnt_id;
    w_ptr        = r_ptr;
    w_hold_cnt   = r_hold_cnt;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en && w_pick_found) begin
          w_next_state = S_GRANT;
          w_gnt        = NUM_REQ'(1) << w_pick_id;
          w_gnt_id     = w_pick_id;
          w_ptr        = (w_pick_id == IDW'(NUM_REQ - 1)) ? '0 : w_pick_id + IDW'(1);
          w_hold_cnt   = '0;
        end
      end
      S_GRANT: begin
        w_hold_cnt = w_hold_max ? r_hold_cnt : r_hold_cnt + HCW'(1);
        // Release is checked first so a drop at the last cycle is not a timeout.
        if (!req[r_gnt_id]) begin
          w_next_state = S_IDLE;
        end else if (w_hold_max) begin
          w_next_state = S_IDLE;
          w_timeout    = 1'b1;
        end else begin
          w_gnt = r_gnt;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_ptr       <= '0;
      r_hold_cnt  <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_gnt       <= w_gnt;
      r_gnt_id    <= w_gnt_id;
      r_ptr       <= w_ptr;
      r_hold_cnt  <= w_hold_cnt;
      r_gnt_valid <= (w_next_state == S_GRANT);
      r_timeout   <= w_timeout;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_ivl_uvm_rr_arbiter.sv
// Testbench for ivl_uvm_rr_arbiter (NUM_REQ=4, MAX_HOLD=8).
module tb_ivl_uvm_rr_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         gnt_valid;
  logic         timeout;

  int vectors = 0;
  int errors  = 0;
  bit mon_armed = 1'b0;

  // Reference model: who owns the bus, how long it has been visible,
  // where the next search starts, last owner, and the timeout pulse.
  int m_owner = -1;
  int m_len   = 0;
  int m_ptr   = 0;
  int m_last  = 0;
  bit m_to    = 1'b0;

  ivl_uvm_rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Zero-or-one-hot checker on gnt, every cycle once reset has been applied.
  always @(negedge clk) begin
    if (mon_armed) begin
      vectors++;
      if (!$onehot0(gnt)) begin
        errors++;
        $display("FAIL zero_one_hot: gnt=%b required zero-or-one-hot", gnt);
      end
    end
  end

  function automatic void model_step();
    int c;
    if (!rst_n) begin
      m_owner = -1; m_len = 0; m_ptr = 0; m_last = 0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      if (en && req != '0) begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (req[c]) begin
            m_owner = c;
            break;
          end
        end
        m_last = m_owner;
        m_ptr  = (m_owner + 1) % N;
        m_len  = 1;
      end
    end else if (!req[m_owner]) begin
      m_owner = -1; m_to = 1'b0;
    end else if (m_len == MH) begin
      m_owner = -1; m_to = 1'b1;
    end else begin
      m_len++; m_to = 1'b0;
    end
  endfunction

  function automatic logic [7:0] model_vec();
    logic [3:0] g;
    g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    return {g, 2'(m_last), (m_owner >= 0), m_to};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; req = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if ({gnt, gnt_id, gnt_valid, timeout} !== 8'h00) begin
        errors++;
        $display("FAIL reset[%0d]: got %b required %b", i, {gnt, gnt_id, gnt_valid, timeout}, 8'h00);
      end
    end
    mon_armed = 1'b1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    en = 1'b1; req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({gnt, gnt_id, gnt_valid, timeout} !== model_vec()) begin
        errors++;
        $display("FAIL single_model[%0d]: got %b required %b", i, {gnt, gnt_id, gnt_valid, timeout}, model_vec());
      end
      vectors++;
      if (gnt !== 4'b0100 || gnt_id !== 2'd2 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL single_grant[%0d]: got gnt=%b id=%0d to=%b required gnt=0100 id=2 to=0", i, gnt, gnt_id, timeout);
      end
    end
    req = 4'b0000;
    tick();
    vectors++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || timeout !== 1'b0 || gnt_id !== 2'd2) begin
      errors++;
      $display("FAIL single_release: got gnt=%b v=%b to=%b id=%0d required gnt=0000 v=0 to=0 id=2", gnt, gnt_valid, timeout, gnt_id);
    end
  endtask

  task automatic test_saturation();
    int order[$];
    int lens[$];
    int gaps[$];
    int cur_len = 0;
    int gap = 0;
    int tos = 0;
    bit prev_v = 1'b0;
    do_reset();
    en = 1'b1; req = 4'b1111;
    for (int i = 0; i < 60 && lens.size() < 5; i++) begin
      tick();
      vectors++;
      if ({gnt, gnt_id, gnt_valid, timeout} !== model_vec()) begin
        errors++;
        $display("FAIL sat_model[%0d]: got %b required %b", i, {gnt, gnt_id, gnt_valid, timeout}, model_vec());
      end
      if (timeout) tos++;
      if (gnt_valid && !prev_v) begin
        order.push_back(int'(gnt_id));
        if (order.size() > 1) gaps.push_back(gap);
        cur_len = 1;
      end else if (gnt_valid) begin
        cur_len++;
      end else if (prev_v) begin
        lens.push_back(cur_len);
        gap = 1;
      end else begin
        gap++;
      end
      prev_v = gnt_valid;
    end
    vectors++;
    if (lens.size() != 5) begin
      errors++;
      $display("FAIL sat_tenures: got %0d tenures required 5 within budget", lens.size());
    end
    for (int t = 0; t < lens.size(); t++) begin
      vectors++;
      if (order[t] != (t % N) || lens[t] != MH) begin
        errors++;
        $display("FAIL sat_tenure[%0d]: got id=%0d len=%0d required id=%0d len=%0d", t, order[t], lens[t], t % N, MH);
      end
    end
    foreach (gaps[g]) begin
      vectors++;
      if (gaps[g] != 1) begin
        errors++;
        $display("FAIL sat_gap[%0d]: got %0d idle cycles required 1", g, gaps[g]);
      end
    end
    vectors++;
    if (tos != 5) begin
      errors++;
      $display("FAIL sat_timeouts: got %0d pulses required 5", tos);
    end
  endtask

  task automatic test_fairness();
    bit seen_idle = 1'b0;
    bit found = 1'b0;
    do_reset();
    en = 1'b1; req = 4'b0001;
    tick();
    vectors++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL fair_first: got gnt=%b id=%0d required gnt=0001 id=0", gnt, gnt_id);
    end
    req = 4'b0101;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      vectors++;
      if ({gnt, gnt_id, gnt_valid, timeout} !== model_vec()) begin
        errors++;
        $display("FAIL fair_model[%0d]: got %b required %b", i, {gnt, gnt_id, gnt_valid, timeout}, model_vec());
      end
      if (!gnt_valid) seen_idle = 1'b1;
      else if (seen_idle) begin
        found = 1'b1;
        vectors++;
        if (gnt_id !== 2'd2 || gnt !== 4'b0100) begin
          errors++;
          $display("FAIL fair_next: got gnt=%b id=%0d required gnt=0100 id=2", gnt, gnt_id);
        end
      end
    end
    vectors++;
    if (!found) begin
      errors++;
      $display("FAIL fair_timeout: got no second grant required grant within 20 cycles");
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_enable_reset();
    do_reset();
    en = 1'b0; req = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
        errors++;
        $display("FAIL en_off[%0d]: got gnt=%b v=%b required gnt=0000 v=0", i, gnt, gnt_valid);
      end
    end
    en = 1'b1;
    tick();
    vectors++;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
      errors++;
      $display("FAIL en_on: got gnt=%b id=%0d required gnt=0010 id=1", gnt, gnt_id);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (gnt !== 4'b0010 || gnt_valid !== 1'b1) begin
        errors++;
        $display("FAIL en_drop_hold[%0d]: got gnt=%b v=%b required gnt=0010 v=1", i, gnt, gnt_valid);
      end
    end
    rst_n = 1'b0;
    tick();
    vectors++;
    if (gnt !== 4'b0000 || timeout !== 1'b0 || gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid: got gnt=%b to=%b id=%0d required gnt=0000 to=0 id=0", gnt, timeout, gnt_id);
    end
    rst_n = 1'b1; en = 1'b1; req = 4'b1111;
    tick();
    vectors++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL rst_search0: got gnt=%b id=%0d required gnt=0001 id=0", gnt, gnt_id);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_release_timeout_tie();
    do_reset();
    en = 1'b1; req = 4'b0001;
    for (int i = 0; i < MH; i++) begin
      tick();
      vectors++;
      if ({gnt, gnt_id, gnt_valid, timeout} !== model_vec()) begin
        errors++;
        $display("FAIL tie_model[%0d]: got %b required %b", i, {gnt, gnt_id, gnt_valid, timeout}, model_vec());
      end
    end
    vectors++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL tie_hold: got gnt=%b required 0001 at last tenure cycle", gnt);
    end
    req = 4'b0000;
    tick();
    vectors++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL tie_release: got gnt=%b to=%b required gnt=0000 to=0", gnt, timeout);
    end
  endtask

  task automatic test_random();
    do_reset();
    en = 1'b1; req = 4'b0000;
    for (int i = 0; i < 2000; i++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      en    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 2) req = 4'($urandom);
      tick();
      vectors++;
      if ({gnt, gnt_id, gnt_valid, timeout} !== model_vec()) begin
        errors++;
        $display("FAIL random[%0d]: got %b required %b", i, {gnt, gnt_id, gnt_valid, timeout}, model_vec());
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; req = '0;
    test_reset();
    test_single();
    test_saturation();
    test_fairness();
    test_enable_reset();
    test_release_timeout_tie();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
